sipo_framed: RTL and testbench
==============================

# sipo_framed

Parametrised, framed serial-in/parallel-out receiver; successor to the plain `sipo` shift register. Adds a bit counter, selectable bit order, a holding register with valid/ready handshake, frame resync, and overrun detection. It sits between a serial bit source and a word-wide consumer, and also replaces cascaded `sipo` chains for wide words. Optional parity checking is compiled in via macro.

## Interface
- `WIDTH`, 8: data word width in bits, ≥2.
- `LSB_FIRST`, 0: 0 = first received bit lands in `q[WIDTH-1]`; 1 = first bit lands in `q[0]`.
- One clock; reset is asynchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `d` in 1: serial data bit, sampled on rising `clk` when `ie`=1.
- `ie` in 1: input enable; a bit is captured only on edges where `ie`=1.
- `sync` in 1: frame resync; discards the partial frame.
- `oe` in 1: output enable; `q` = holding register when 1, all-zeros when 0.
- `q` out WIDTH: last completed word, gated by `oe`.
- `valid` out 1: holding register contains an unconsumed word.
- `ready` in 1: consumer accepts the word on an edge where `valid`=1 and `ready`=1.
- `overrun` out 1: sticky; a completed word was dropped.
- `bit_cnt` out $clog2(WIDTH+1): bits captured in the current frame.
- `parity_err` out 1: parity result for the word in the holding register (see Configuration).

## Operation
- State: shift register `sr`, counter `cnt`, holding register `hold`, flags `valid`, `overrun`, `parity_err`. `bit_cnt`=`cnt`.
- Frame length F = WIDTH (WIDTH+1 with parity).
- **Capture.** On an edge with `ie`=1, `d` is captured and `cnt` increments.
  - MSB-first: `sr` <= {sr[WIDTH-2:0], d}.
  - LSB-first: `sr` <= {d, sr[WIDTH-1:1]}.
- **Completion.** On the edge that captures bit F-1 (`cnt`=F-1, `ie`=1), the assembled word (`sr` combined with `d`) is the completed word.
  - `cnt` <= 0.
  - If the holding register is free (`valid`=0, or `ready`=1 on that edge): `hold` <= word and `valid` <= 1.
  - Otherwise the word is dropped, `hold` is unchanged, and `overrun` <= 1.
- **Consume.** On an edge with `valid`=1, `ready`=1 and no completion, `valid` <= 0. Consume and completion on the same edge: `hold` reloads and `valid` stays 1, with no overrun.
- **Resync.** `sync`=1 has priority over capture.
  - `sr` <= 0 and `cnt` <= 0.
  - If `ie`=1 on the same edge, `d` becomes bit 0 of a new frame and `cnt` <= 1.
  - `hold` and `valid` are unaffected.
  - `overrun` clears only on `rst`.
- **Idle.** With `ie`=0 and `sync`=0, `sr` and `cnt` hold.
- **Reset.** `rst` clears everything immediately, including mid-frame. Values: `sr`=0, `cnt`=0, `hold`=0, `q`=0, `valid`=0, `overrun`=0, `parity_err`=0, `bit_cnt`=0.

## Timing
- Latency is 0 cycles: `q` and `valid` update on the same edge that samples the final frame bit.
- The receiver is fully pipelined. Back-to-back frames with `ie` held at 1 complete every F cycles with no dead cycle.
- `q` gating by `oe` is combinational. `valid`, `overrun` and `parity_err` are never gated.
- `ready` is sampled only at rising edges. Asserting `ready` while `valid`=0 has no effect.

## Configuration
- Macro: `SIPO_PARITY_EN`.
- **Defined.**
  - F = WIDTH+1; the final bit is an even-parity bit and is not stored in `sr`.
  - At completion, `parity_err` <= (XOR of data bits) XOR (parity bit).
  - `parity_err` is loaded together with `hold`, and keeps its value when a word is dropped on overrun.
- **Undefined.**
  - F = WIDTH.
  - `parity_err` is tied to 0.
  - The port list is identical in both builds.

## Test plan
Default configuration for all scenarios: WIDTH=8, no parity unless stated.
- **MSB-first capture.** LSB_FIRST=0, `oe`=1, `ie`=1, bits 1,1,0,0,0,0,0,1 -> `q`=0xC1 and `valid`=1 on the 8th edge; `bit_cnt` sequences 1..7, then 0.
- **LSB-first capture.** LSB_FIRST=1, same bit sequence -> `q`=0x83. Then drop `oe` to 0 -> `q`=0x00 while `valid` stays 1.
- **Overrun and back-to-back.** `ready`=0, two back-to-back frames 0xC1 then 0x55 -> `q`=0xC1, `overrun`=1 at the 16th edge. Repeat with `ready`=1 at the 16th edge -> `q`=0x55, `valid`=1, `overrun`=0.
- **Resync and idle.** Pulse `sync` after 3 bits, then send 8 bits of 0xA5 -> `q`=0xA5. `ie` low for 5 cycles mid-frame -> `bit_cnt` holds and the word is still correct.
- **Reset mid-operation.** Assert `rst` asynchronously mid-frame, away from a clock edge, while `valid`=1 and `overrun`=1 -> all outputs 0 immediately. The next full frame decodes correctly.
- **Parity.** With `SIPO_PARITY_EN`: 0xC1 followed by parity bit 1 -> `parity_err`=0; with parity bit 0 -> `parity_err`=1; a 9th bit is required before `valid` asserts.

Source files
------------

// File: rtl/sipo_framed.sv
// Framed serial-in/parallel-out receiver with holding register, valid/ready handshake,
// resync and sticky overrun. Define SIPO_PARITY_EN to append an even-parity bit to each frame.
module sipo_framed #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       d,
    input  logic                       ie,
    input  logic                       sync,
    input  logic                       oe,
    output logic [WIDTH-1:0]           q,
    output logic                       valid,
    input  logic                       ready,
    output logic                       overrun,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       parity_err
);
    localparam int CW = $clog2(WIDTH+1);
`ifdef SIPO_PARITY_EN
    localparam int F = WIDTH + 1;
`else
    localparam int F = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(F - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_free;

    // A resync shifts the new bit into an empty register, so the same shifter serves both paths.
    assign w_base  = sync ? '0 : r_sr;
    assign w_shift = LSB_FIRST ? {d, w_base[WIDTH-1:1]} : {w_base[WIDTH-2:0], d};
    assign w_done  = ie && !sync && (r_cnt == LAST);
    assign w_free  = !r_valid || ready;

`ifdef SIPO_PARITY_EN
    logic w_perr;
    logic r_perr;

    // The parity bit is never stored: the word is already complete in the shift register.
    assign w_word     = r_sr;
    assign w_perr     = (^r_sr) ^ d;
    assign parity_err = r_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_perr <= 1'b0;
        else if (w_done && w_free) r_perr <= w_perr;
    end
`else
    assign w_word     = w_shift;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (sync) begin
            r_sr  <= ie ? w_shift : '0;
            r_cnt <= ie ? CW'(1) : '0;
        end else if (ie) begin
            r_cnt <= w_done ? '0 : r_cnt + 1'b1;
`ifdef SIPO_PARITY_EN
            if (!w_done) r_sr <= w_shift;
`else
            r_sr <= w_shift;
`endif
        end
    end

    // Completion wins over consume, so a same-edge consume and reload keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_done) begin
            if (w_free) begin
                r_hold  <= w_word;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign q       = oe ? r_hold : '0;
    assign valid   = r_valid;
    assign overrun = r_overrun;
    assign bit_cnt = r_cnt;

endmodule

// File: tb/tb_sipo_framed.sv
// Directed + randomized bench for sipo_framed; an MSB-first and an LSB-first instance share stimulus
// and are checked against a frame-level reference model built from bit lists.
module tb_sipo_framed;
    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d = 1'b0, ie = 1'b0, sync = 1'b0, oe = 1'b1, ready = 1'b0;
    logic [W-1:0] q_m, q_l;
    logic valid_m, valid_l, ovr_m, ovr_l, perr_m, perr_l;
    logic [3:0] cnt_m, cnt_l;

    always #5 clk = ~clk;

    sipo_framed #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .d(d), .ie(ie), .sync(sync), .oe(oe), .q(q_m), .valid(valid_m),
        .ready(ready), .overrun(ovr_m), .bit_cnt(cnt_m), .parity_err(perr_m));
    sipo_framed #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .d(d), .ie(ie), .sync(sync), .oe(oe), .q(q_l), .valid(valid_l),
        .ready(ready), .overrun(ovr_l), .bit_cnt(cnt_l), .parity_err(perr_l));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bits of the current frame, plus the consumer-visible state.
    bit       m_bits[$];
    bit [W-1:0] m_hold_m, m_hold_l;
    bit       m_valid, m_ovr, m_perr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("q_msb", 32'(q_m), oe ? 32'(m_hold_m) : 32'd0);
        chk("q_lsb", 32'(q_l), oe ? 32'(m_hold_l) : 32'd0);
        chk("valid_msb", 32'(valid_m), 32'(m_valid));
        chk("valid_lsb", 32'(valid_l), 32'(m_valid));
        chk("overrun_msb", 32'(ovr_m), 32'(m_ovr));
        chk("overrun_lsb", 32'(ovr_l), 32'(m_ovr));
        chk("bit_cnt_msb", 32'(cnt_m), 32'(m_bits.size()));
        chk("bit_cnt_lsb", 32'(cnt_l), 32'(m_bits.size()));
        chk("parity_msb", 32'(perr_m), 32'(m_perr));
        chk("parity_lsb", 32'(perr_l), 32'(m_perr));
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_hold_m = '0; m_hold_l = '0;
        m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    endtask

    // One clock edge: drive inputs, advance the model by the frame rules, check 1 time unit later.
    task automatic step(input logic d_i, input logic ie_i, input logic sync_i,
                        input logic rdy_i, input logic oe_i);
        bit done;
        bit [W-1:0] wm, wl;
        bit px;
        d = d_i; ie = ie_i; sync = sync_i; ready = rdy_i; oe = oe_i;
        @(posedge clk);
        done = 1'b0;
        if (sync_i) begin
            m_bits.delete();
            if (ie_i) m_bits.push_back(d_i);
        end else if (ie_i) begin
            m_bits.push_back(d_i);
            if (m_bits.size() == F) begin
                done = 1'b1;
                px = 1'b0;
                for (int i = 0; i < F; i++) px ^= m_bits[i];
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = m_bits[i];
                    wl[i]     = m_bits[i];
                end
                if (!m_valid || rdy_i) begin
                    m_hold_m = wm; m_hold_l = wl; m_valid = 1'b1;
`ifdef SIPO_PARITY_EN
                    m_perr = px;
`endif
                end else begin
                    m_ovr = 1'b1;
                end
                m_bits.delete();
            end
        end
        if (!done && m_valid && rdy_i) m_valid = 1'b0;
        #1;
        chk_all();
    endtask

    // Sends w MSB-first (plus its even-parity bit when enabled); ready only on the frame's last edge.
    task automatic send_word(input logic [W-1:0] w, input logic rdy_last);
        for (int i = W - 1; i >= 0; i--)
            step(w[i], 1'b1, 1'b0, (i == 0 && F == W) ? rdy_last : 1'b0, 1'b1);
`ifdef SIPO_PARITY_EN
        step(^w, 1'b1, 1'b0, rdy_last, 1'b1);
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk_all();
        chk("rst_q_zero", 32'(q_m), 32'd0);
        chk("rst_valid_zero", 32'(valid_m), 32'd0);
        chk("rst_ovr_zero", 32'(ovr_l), 32'd0);
        chk("rst_cnt_zero", 32'(cnt_m), 32'd0);
        #2 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        chk_all();
        @(negedge clk);
        rst = 1'b0;

        // MSB/LSB capture of bits 1,1,0,0,0,0,0,1
        send_word(8'hC1, 1'b0);
        chk("capture_msb", 32'(q_m), 32'hC1);
        chk("capture_lsb", 32'(q_l), 32'h83);
        chk("capture_valid", 32'(valid_m), 32'd1);
        chk("capture_cnt", 32'(cnt_m), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("oe_low_q", 32'(q_l), 32'd0);
        chk("oe_low_valid", 32'(valid_l), 32'd1);

        // Overrun on back-to-back frames with no consumer
        async_reset();
        send_word(8'hC1, 1'b0);
        send_word(8'h55, 1'b0);
        chk("ovr_q", 32'(q_m), 32'hC1);
        chk("ovr_flag", 32'(ovr_m), 32'd1);
        async_reset();
        send_word(8'hC1, 1'b0);
        send_word(8'h55, 1'b1);
        chk("reload_q", 32'(q_m), 32'h55);
        chk("reload_valid", 32'(valid_m), 32'd1);
        chk("reload_ovr", 32'(ovr_m), 32'd0);

        // Resync after a partial frame, then idle gaps mid-frame
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("sync_cnt", 32'(cnt_m), 32'd0);
        send_word(8'hA5, 1'b0);
        chk("sync_q", 32'(q_m), 32'hA5);
        for (int i = W - 1; i >= 4; i--) step(i[0] ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("idle_cnt", 32'(cnt_m), 32'd4);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, (F == W) ? 1'b1 : 1'b0, 1'b1);
`ifdef SIPO_PARITY_EN
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
`endif
        chk("idle_q", 32'(q_m), 32'h5C);

        // Reset mid-frame while valid and overrun are both set
        send_word(8'h0F, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_ovr", 32'(ovr_m), 32'd1);
        async_reset();
        send_word(8'h96, 1'b0);
        chk("post_rst_q", 32'(q_m), 32'h96);

`ifdef SIPO_PARITY_EN
        async_reset();
        for (int i = W - 1; i >= 0; i--) step(i == 7 || i == 6 || i == 0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("par_wait_valid", 32'(valid_m), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("par_ok_valid", 32'(valid_m), 32'd1);
        chk("par_ok", 32'(perr_m), 32'd0);
        for (int i = W - 1; i >= 0; i--) step(i == 7 || i == 6 || i == 0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("par_bad", 32'(perr_m), 32'd1);
`endif

        // Randomized traffic
        async_reset();
        for (int k = 0; k < 800; k++)
            step(1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0),
                 1'($urandom), ($urandom_range(0, 7) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
